// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between per-core instruction and data requesters.
package ram_port_arbiter_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int CPUS = 2,
  parameter int DBURST = 2,
  parameter int STARVE_MAX = 4,
  localparam int IW = CPUS > 1 ? $clog2(CPUS) : 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0][31:0] iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS-1:0][31:0] dload,
  input  ramstate_t            ramstate,
  input  logic [31:0]          ramload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  output logic                 gnt_valid,
  output logic                 gnt_data,
  output logic [IW-1:0]        gnt_id
);
  typedef enum logic [1:0] {IDLE, DXFER, IXFER} state_t;
  localparam int BW = DBURST > 1 ? $clog2(DBURST) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  state_t state, next;
  logic [IW-1:0] owner, dptr, iptr, dwin, iwin, nxt_owner;
  logic [BW-1:0] beat;
  logic [SW-1:0] starve;
  logic [CPUS-1:0] dreq;
  logic is_data, is_wr, take_d, take_i, own_req, access, last;
  assign dreq = dREN | dWEN;
  assign take_d = |dreq && !(starve == SW'(STARVE_MAX) && |iREN);
  assign take_i = !take_d && |iREN;
  assign own_req = is_data ? dreq[owner] : iREN[owner];
  assign access = ramstate == ACCESS;
  assign last = beat == BW'(DBURST - 1);
  assign nxt_owner = owner == IW'(CPUS - 1) ? '0 : owner + IW'(1);
  // Scan downward so the requester closest to the pointer is assigned last and wins.
  always_comb begin
    dwin = '0;
    iwin = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      if (dreq[(int'(dptr) + k) % CPUS]) dwin = IW'((int'(dptr) + k) % CPUS);
      if (iREN[(int'(iptr) + k) % CPUS]) iwin = IW'((int'(iptr) + k) % CPUS);
    end
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    if (state == IDLE) next = take_d ? DXFER : take_i ? IXFER : IDLE;
    else if (!own_req || (access && (state == IXFER || last))) next = IDLE;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      owner <= '0;
      is_data <= 1'b0;
      is_wr <= 1'b0;
      beat <= '0;
      dptr <= '0;
      iptr <= '0;
      starve <= '0;
    end else if (state == IDLE) begin
      if (take_d || take_i) begin
        owner <= take_d ? dwin : iwin;
        is_data <= take_d;
        is_wr <= take_d && dWEN[dwin];
        beat <= '0;
      end
    end else if (own_req && access) begin
      if (state == IXFER) begin
        iptr <= nxt_owner;
        starve <= '0;
      end else begin
        beat <= beat + BW'(1);
        if (last) begin
          dptr <= nxt_owner;
          starve <= !(|iREN) ? '0 : starve == SW'(STARVE_MAX) ? starve : starve + SW'(1);
        end
      end
    end
  always_comb begin
    ramREN = own_req && (state == IXFER || (state == DXFER && !is_wr));
    ramWEN = own_req && state == DXFER && is_wr;
    ramaddr = state == DXFER ? daddr[owner] : state == IXFER ? iaddr[owner] : '0;
    ramstore = state == DXFER ? dstore[owner] : '0;
    iwait = '1;
    dwait = '1;
    iwait[owner] = !(state == IXFER && own_req && access);
    dwait[owner] = !(state == DXFER && own_req && access);
    gnt_valid = state != IDLE;
    gnt_data = gnt_valid && is_data;
    gnt_id = gnt_valid ? owner : '0;
    iload = {CPUS{ramload}};
    dload = {CPUS{ramload}};
  end
endmodule
